// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants, occupancy-state enum and sizing helpers
// for the async_fifo read-side streamer.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    EMPTY_BUF,
    PARTIAL,
    FULL_BUF
  } occ_state_e;

  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// skid_buffer: small circular store that absorbs the FIFO read latency
// and presents the head word on a valid/ready stream.
module skid_buffer
  import fifo_pkg::*;
#(
  parameter  int DW    = DATA_WIDTH_DEF,
  parameter  int DEPTH = 3,
  localparam int PW    = ptr_w(DEPTH),
  localparam int OW    = occ_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cap,
  input  logic [DW-1:0] cap_data,
  input  logic          flush,
  output logic [OW-1:0] occ,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready,
  output logic          pop
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  occ_state_e    state_q, state_d;
  logic          wr;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign occ     = occ_q;
  assign m_valid = (state_q != EMPTY_BUF);
  assign m_data  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    wr       = cap && !flush;
    pop      = m_valid && m_ready && !flush;
    if (wr) begin
      mem_d[wr_ptr_q] = cap_data;
      wr_ptr_d        = nxt(wr_ptr_q);
    end
    if (pop) rd_ptr_d = nxt(rd_ptr_q);
    // flush drops everything and realigns the read side
    unique case (1'b1)
      flush: begin
        occ_d    = '0;
        rd_ptr_d = wr_ptr_q;
      end
      (wr && !pop): occ_d = occ_q + OW'(1);
      (pop && !wr): occ_d = occ_q - OW'(1);
      default: ;
    endcase
    unique case (1'b1)
      (occ_d == '0):          state_d = EMPTY_BUF;
      (occ_d == OW'(DEPTH)):  state_d = FULL_BUF;
      default:                state_d = PARTIAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      state_q  <= EMPTY_BUF;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      state_q  <= state_d;
    end
  end

  a_occ: assert property (
    @(posedge clk) disable iff (rst)
    occ_q <= OW'(DEPTH));

  a_state: assert property (
    @(posedge clk) disable iff (rst)
    (state_q == FULL_BUF) == (occ_q == OW'(DEPTH)));

endmodule

// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: R_CLK-domain drain for async_fifo; credit-based R_EN
// feeds a skid buffer so M_READY never reaches R_EN combinationally.
module fifo_rd_streamer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SKID_DEPTH = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  R_CLK,
  input  logic                  RRST,
  input  logic                  EMPTY,
  input  logic [DATA_WIDTH-1:0] FIFO_DATA,
  output logic                  R_EN,
  input  logic                  FLUSH,
  output logic                  M_VALID,
  output logic [DATA_WIDTH-1:0] M_DATA,
  input  logic                  M_READY,
  output logic [CNT_WIDTH-1:0]  RD_COUNT
);

  localparam int OW = occ_w(SKID_DEPTH);

  logic                 inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [OW-1:0]        occ;
  logic                 pop;
  logic                 credit_ok;

  always_comb begin
    // the word in flight already holds a slot
    credit_ok  = (int'(occ) + int'(inflight_q)) < SKID_DEPTH;
    R_EN       = !EMPTY && !FLUSH && !RRST && credit_ok;
    inflight_d = R_EN;
    cnt_d      = pop ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  end

  always_ff @(posedge R_CLK) begin
    if (RRST) begin
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
    end
  end

  assign RD_COUNT = cnt_q;

  skid_buffer #(
    .DW    (DATA_WIDTH),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk      (R_CLK),
    .rst      (RRST),
    .cap      (inflight_q),
    .cap_data (FIFO_DATA),
    .flush    (FLUSH),
    .occ      (occ),
    .m_valid  (M_VALID),
    .m_data   (M_DATA),
    .m_ready  (M_READY),
    .pop      (pop)
  );

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// tb_fifo_rd_streamer: queue-modelled FIFO source plus a scoreboard
// of expected stream words, count and read-issue behaviour.
module tb_fifo_rd_streamer;

  localparam int DW    = 8;
  localparam int DEPTH = 3;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rrst;
  logic          empty;
  logic          flush;
  logic          m_ready;
  logic [DW-1:0] fifo_data;
  logic          r_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [CW-1:0] rd_count;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] fifo_q [$];
  logic [7:0] exp_q  [$];
  logic       inf_v;
  logic [7:0] inf_w;
  int         exp_cnt;
  int         n_reads;
  int         base;
  int         cnt_before;

  always #5 clk = ~clk;

  fifo_rd_streamer #(
    .DATA_WIDTH (DW),
    .SKID_DEPTH (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .R_CLK     (clk),
    .RRST      (rrst),
    .EMPTY     (empty),
    .FIFO_DATA (fifo_data),
    .R_EN      (r_en),
    .FLUSH     (flush),
    .M_VALID   (m_valid),
    .M_DATA    (m_data),
    .M_READY   (m_ready),
    .RD_COUNT  (rd_count)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic cycle();
    logic       s_ren;
    logic       s_mv;
    logic [7:0] s_md;
    logic [7:0] w;
    logic       exp_ren;
    logic       pop;
    empty = (fifo_q.size() == 0);
    @(negedge clk);
    s_ren   = r_en;
    s_mv    = m_valid;
    s_md    = m_data;
    exp_ren = !empty && !flush && !rrst &&
              ((exp_q.size() + int'(inf_v)) < DEPTH);
    check("r_en", 32'(s_ren), 32'(exp_ren));
    check("m_valid", 32'(s_mv), 32'(exp_q.size() != 0));
    if (s_mv && exp_q.size() != 0)
      check("m_data", 32'(s_md), 32'(exp_q[0]));
    check("rd_count", 32'(rd_count), 32'(exp_cnt));
    w = 8'h00;
    if (rrst) begin
      exp_q.delete();
      inf_v   = 1'b0;
      exp_cnt = 0;
    end else begin
      pop = s_mv && m_ready && !flush && (exp_q.size() != 0);
      if (pop) begin
        void'(exp_q.pop_front());
        exp_cnt = (exp_cnt + 1) % (1 << CW);
      end
      if (flush) exp_q.delete();
      else if (inf_v) exp_q.push_back(inf_w);
      if (s_ren) begin
        n_reads++;
        if (fifo_q.size() != 0) w = fifo_q.pop_front();
      end
      inf_v = s_ren;
      inf_w = w;
    end
    @(posedge clk);
    #1;
    fifo_data = w;
  endtask

  initial begin
    rrst      = 1'b1;
    empty     = 1'b1;
    flush     = 1'b0;
    m_ready   = 1'b0;
    fifo_data = '0;
    inf_v     = 1'b0;
    inf_w     = '0;
    exp_cnt   = 0;
    n_reads   = 0;
    @(posedge clk);
    #1;

    // reset then idle with an empty FIFO
    repeat (2) cycle();
    check("rst_m_data", 32'(m_data), 32'h0);
    rrst = 1'b0;
    repeat (3) cycle();
    check("idle_reads", n_reads, 0);

    // streaming 0x01..0x0A with downstream always ready
    for (int i = 1; i <= 10; i++) fifo_q.push_back(8'(i));
    m_ready = 1'b1;
    repeat (16) cycle();
    check("stream_count", 32'(rd_count), 32'd10);
    check("stream_reads", n_reads, 10);

    // backpressure: only DEPTH reads, head held
    m_ready = 1'b0;
    base    = n_reads;
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'(8'h11 + i));
    repeat (5) cycle();
    check("bp_reads", n_reads - base, DEPTH);
    check("bp_valid", 32'(m_valid), 32'h1);
    check("bp_head", 32'(m_data), 32'h11);
    m_ready = 1'b1;
    repeat (12) cycle();
    check("bp_count", 32'(rd_count), 32'h0);

    // capture and pop in the same cycle at occ=1
    m_ready = 1'b0;
    fifo_q.push_back(8'h21);
    fifo_q.push_back(8'h22);
    repeat (2) cycle();
    m_ready = 1'b1;
    cycle();
    check("sim_valid", 32'(m_valid), 32'h1);
    check("sim_head", 32'(m_data), 32'h22);
    repeat (3) cycle();

    // flush with occ=2 and one word in flight
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) fifo_q.push_back(8'(8'h31 + i));
    repeat (3) cycle();
    cnt_before = int'(rd_count);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("flush_valid", 32'(m_valid), 32'h0);
    check("flush_count", 32'(rd_count), 32'(cnt_before));
    m_ready = 1'b1;
    repeat (2) cycle();
    check("flush_next_v", 32'(m_valid), 32'h1);
    check("flush_next_d", 32'(m_data), 32'h34);
    repeat (4) cycle();

    // reset in the middle of a stream
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'h41 + i));
    repeat (4) cycle();
    rrst = 1'b1;
    cycle();
    check("mrst_valid", 32'(m_valid), 32'h0);
    check("mrst_data", 32'(m_data), 32'h0);
    check("mrst_count", 32'(rd_count), 32'h0);
    fifo_q.delete();
    rrst = 1'b0;

    // 17 pops through a 4-bit counter
    for (int i = 0; i < 17; i++) fifo_q.push_back(8'(8'h50 + i));
    repeat (22) cycle();
    check("wrap_count", 32'(rd_count), 32'h1);
    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
